// File: rtl/player_ctrl_pkg.sv
// Shared game codes: game state, player animation state and facing.
package player_ctrl_pkg;

  typedef enum logic [3:0] {
    GS_TITLE    = 4'd0,
    GS_STAFF    = 4'd1,
    GS_STAGE1   = 4'd2,
    GS_SUCCESS1 = 4'd3,
    GS_STAGE2   = 4'd4,
    GS_SUCCESS2 = 4'd5,
    GS_STAGE3   = 4'd6,
    GS_SUCCESS3 = 4'd7,
    GS_FAIL     = 4'd8
  } game_state_e;

  typedef enum logic [1:0] {
    PS_IDLE = 2'd0,
    PS_WALK = 2'd1,
    PS_HURT = 2'd2,
    PS_DEAD = 2'd3
  } player_state_e;

  typedef enum logic [1:0] {
    FACE_UP    = 2'd0,
    FACE_DOWN  = 2'd1,
    FACE_LEFT  = 2'd2,
    FACE_RIGHT = 2'd3
  } facing_e;

  localparam logic [1:0] HEART_FULL = 2'd3;

  // Playable stages are the three STAGEn codes.
  function automatic logic in_stage(input logic [3:0] s);
    return (s == GS_STAGE1) || (s == GS_STAGE2) || (s == GS_STAGE3);
  endfunction

endpackage

// File: rtl/player_ctrl_tick_gen.sv
// Movement tick divider: one-cycle tick every DIV cycles while enabled.
module tick_gen #(
  parameter int DIV = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count while enabled, wrap on the tick cycle, park at 0 when disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cnt <= '0;
    else if (!en)    cnt <= '0;
    else if (tick)   cnt <= '0;
    else             cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/player_ctrl.sv
// Player movement, damage and lives controller for the stage screens.
module player_ctrl
  import player_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = 1000000,
  parameter int X_MAX     = 304,
  parameter int Y_MAX     = 224,
  parameter int SPAWN_X   = 16,
  parameter int SPAWN_Y   = 112,
  parameter int INV_TICKS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       hit,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic [1:0] player_state,
  output logic [1:0] facing,
  output logic [1:0] heart,
  output logic       dead
);

  localparam int INV_W = (INV_TICKS < 1) ? 1 : $clog2(INV_TICKS + 1);
  localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INV_TICKS);
  localparam logic [INV_W-1:0] INV_ONE  = INV_W'(1);
  localparam logic [9:0] XM = 10'(X_MAX);
  localparam logic [9:0] YM = 10'(Y_MAX);
  localparam logic [9:0] SX = 10'(SPAWN_X);
  localparam logic [9:0] SY = 10'(SPAWN_Y);

  logic [9:0]       x_q, x_d, y_q, y_d;
  player_state_e    ps_q, ps_d;
  facing_e          face_q, face_d;
  logic [1:0]       heart_q, heart_d;
  logic             dead_q, dead_d;
  logic [INV_W-1:0] inv_q, inv_d;
  logic [3:0]       prev_q;

  logic    stage, entry, tick;
  logic    v_act, h_act, dir_ok;
  facing_e dir_f;

  assign stage = in_stage(state);
  assign entry = stage && (prev_q != state);

  // Divider is held in reset on the entry cycle so the stage starts from count 0.
  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (stage && !entry),
    .tick (tick)
  );

  // Vertical wins when unambiguous; horizontal only as fallback.
  always_comb begin
    v_act  = key_up ^ key_down;
    h_act  = key_left ^ key_right;
    dir_ok = v_act || h_act;
    if (v_act)      dir_f = key_up ? FACE_UP : FACE_DOWN;
    else            dir_f = key_left ? FACE_LEFT : FACE_RIGHT;
  end

  // Next-state: stage entry > (tick move, then hit damage); DEAD and non-stage freeze.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    ps_d    = ps_q;
    face_d  = face_q;
    heart_d = heart_q;
    inv_d   = inv_q;
    dead_d  = 1'b0;
    if (entry) begin
      x_d     = SX;
      y_d     = SY;
      ps_d    = PS_IDLE;
      face_d  = FACE_DOWN;
      heart_d = HEART_FULL;
      inv_d   = '0;
    end else if (stage && ps_q != PS_DEAD) begin
      if (tick) begin
        if (dir_ok) begin
          face_d = dir_f;
          case (dir_f)
            FACE_UP:    y_d = (y_q == 10'd0) ? 10'd0 : y_q - 10'd1;
            FACE_DOWN:  y_d = (y_q >= YM)    ? YM    : y_q + 10'd1;
            FACE_LEFT:  x_d = (x_q == 10'd0) ? 10'd0 : x_q - 10'd1;
            FACE_RIGHT: x_d = (x_q >= XM)    ? XM    : x_q + 10'd1;
            default:    ;
          endcase
        end
        if (inv_q != '0) inv_d = inv_q - INV_ONE;
        // HURT holds until the invulnerability window closes on this tick.
        if (ps_q != PS_HURT || inv_q <= INV_ONE)
          ps_d = dir_ok ? PS_WALK : PS_IDLE;
      end
      if (hit && inv_q == '0 && heart_q != 2'd0) begin
        heart_d = heart_q - 2'd1;
        inv_d   = INV_LOAD;
        if (heart_q == 2'd1) begin
          ps_d   = PS_DEAD;
          dead_d = 1'b1;
        end else begin
          ps_d   = PS_HURT;
        end
      end
    end
  end

  // Player register set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q     <= SX;
      y_q     <= SY;
      ps_q    <= PS_IDLE;
      face_q  <= FACE_DOWN;
      heart_q <= HEART_FULL;
      dead_q  <= 1'b0;
      inv_q   <= '0;
      prev_q  <= GS_TITLE;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      ps_q    <= ps_d;
      face_q  <= face_d;
      heart_q <= heart_d;
      dead_q  <= dead_d;
      inv_q   <= inv_d;
      prev_q  <= state;
    end
  end

  assign player_x     = x_q;
  assign player_y     = y_q;
  assign player_state = ps_q;
  assign facing       = face_q;
  assign heart        = heart_q;
  assign dead         = dead_q;

endmodule

// File: doc/player_ctrl.md
PLAYER_CTRL -- requirements
Module: player_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 1000000, clk cycles per movement tick (100 Hz at 100 MHz).
REQ-002 Parameter X_MAX, default 304, largest player_x (320-wide frame minus 16-px sprite); X min is 0.
REQ-003 Parameter Y_MAX, default 224, largest player_y; Y min is 0.
REQ-004 Parameters SPAWN_X and SPAWN_Y, defaults 16 and 112, stage start position.
REQ-005 Parameter INV_TICKS, default 100, invulnerability length in ticks after a hit.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-008 state  input  4  game state code: TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8.
REQ-009 key_up, key_down, key_left, key_right  input  1 each  level-held direction keys from the keyboard decoder.
REQ-010 hit  input  1  one-cycle damage pulse from collision logic.
REQ-011 player_x  output  10  sprite left edge, 320x240 coordinate space.
REQ-012 player_y  output  10  sprite top edge.
REQ-013 player_state  output  2  IDLE=0, WALK=1, HURT=2, DEAD=3; feeds the sprite drawer.
REQ-014 facing  output  2  UP=0, DOWN=1, LEFT=2, RIGHT=3.
REQ-015 heart  output  2  remaining lives, 0..3.
REQ-016 dead  output  1  one-cycle pulse when heart reaches 0.

Function
REQ-017 "In stage" SHALL mean state is 2, 4 or 6.
REQ-018 The tick counter SHALL count 0..TICK_DIV-1 while in stage, assert tick for the one cycle where count = TICK_DIV-1, then wrap to 0, and SHALL be held at 0 while not in stage.
REQ-019 Stage entry (the registered previous state differs from state, and state is in stage) SHALL, on the next edge, load x = SPAWN_X, y = SPAWN_Y, heart = 3, player_state = IDLE, facing = DOWN, invulnerability counter = 0, and tick counter = 0.
REQ-020 Stage entry SHALL take priority over a simultaneous hit or tick.
REQ-021 Direction resolution: the vertical axis is active when exactly one of up or down is held; if vertical is active it SHALL be used alone; otherwise the horizontal axis is used when exactly one of left or right is held; otherwise there is no direction.
REQ-022 On tick with a resolved direction, the matching coordinate SHALL move by 1 and clamp to 0..X_MAX or 0..Y_MAX, and facing SHALL update even when the move is clamped.
REQ-023 On tick, if player_state is not HURT or DEAD, player_state SHALL become WALK when a direction is resolved and IDLE otherwise.
REQ-024 A hit while in stage, with player_state not DEAD and the invulnerability counter at 0, SHALL decrement heart, set player_state = HURT and load the counter with INV_TICKS on the next edge.
REQ-025 All other hits SHALL be ignored.
REQ-026 The invulnerability counter SHALL decrement on each tick while non-zero; on the tick where it goes 1->0, a HURT player_state SHALL resolve to WALK or IDLE per REQ-023.
REQ-027 A hit and a tick in the same cycle SHALL both apply; the move is applied and the damage is applied.
REQ-028 When heart goes 1->0, player_state SHALL become DEAD and dead SHALL pulse high for exactly the following cycle.
REQ-029 In DEAD, position, facing and heart SHALL freeze until the next stage entry.
REQ-030 Outside stage, all outputs SHALL hold their values, with no movement and no damage.
REQ-031 Key inputs SHALL be sampled only on tick; there is no edge detection.

Reset
REQ-032 While rst = 0, the block SHALL immediately force: player_x = SPAWN_X, player_y = SPAWN_Y, player_state = IDLE, facing = DOWN, heart = 3, dead = 0, tick and invulnerability counters = 0, and previous-state register = TITLE.
REQ-033 Reset asserted mid-hurt or mid-tick SHALL discard all pending activity, and operation SHALL resume from REQ-032 values on the first edge after release.

Structure
REQ-034 The game state codes, the player_state codes and the facing codes SHALL live in the shared game package used by the display and draw modules.
REQ-035 The tick counter SHALL be a sub-module named tick_gen, with ports clk, rst, en, tick and parameter DIV.
REQ-036 All remaining logic SHALL be a single always-block register set plus next-state combinational logic.

Verification (TICK_DIV=4, INV_TICKS=3)
REQ-037 Reset release, then state 0->2 -> next cycle x=16, y=112, heart=3, player_state=IDLE, facing=DOWN.
REQ-038 key_right held for 5 ticks -> x=21, player_state=WALK; release -> IDLE at the next tick.
REQ-039 x at 304 with key_right held -> x stays 304 and facing=RIGHT; up and down held together with left -> only x decreases.
REQ-040 hit, then a second hit 2 ticks later -> heart=2 only, HURT for 3 ticks, then IDLE.
REQ-041 Three hits spaced 4 ticks apart -> heart=0, DEAD, dead high for 1 cycle, keys ignored; state 2->4 -> respawn at 16,112 with heart=3.
REQ-042 rst pulsed low mid-HURT -> outputs at reset values asynchronously, before the next clk edge.
